// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage_pkg: shared widths, register-zero constant, ALU codes and the ID/EX register layout.
package ex_operand_stage_pkg;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam logic [RW-1:0] REG_ZERO = '0;

    typedef enum logic [CW-1:0] {
        ALU_ADD  = 4'b0000, ALU_SUB = 4'b0001, ALU_MUL  = 4'b0010, ALU_SRA  = 4'b0011,
        ALU_SLA  = 4'b0100, ALU_AND = 4'b0101, ALU_XOR  = 4'b0110, ALU_OR   = 4'b0111,
        ALU_NOR  = 4'b1000, ALU_ADDU = 4'b1001, ALU_BNE = 4'b1010, ALU_BEQ  = 4'b1011,
        ALU_ADDI = 4'b1100
    } alu_ctrl_e;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic          alu_src;
        logic [CW-1:0] alu_ctrl;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } ex_regs_t;
endpackage

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: decode inputs, MEM/WB forwarding sources and EX outputs of the operand stage.
interface ex_operand_stage_if;
    import ex_operand_stage_pkg::*;
    logic          stall, flush, id_valid;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          id_alu_src;
    logic [CW-1:0] id_alu_ctrl;
    logic          id_reg_write, id_mem_read, id_mem_write;
    logic          mem_reg_write, wb_reg_write;
    logic [RW-1:0] mem_rd, wb_rd;
    logic [DW-1:0] mem_result, wb_result;
    logic          hazard_stall, ex_valid;
    logic [DW-1:0] alu_a, alu_b, ex_store_data;
    logic [CW-1:0] alu_ctrl;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write, ex_mem_read, ex_mem_write;

    modport master (
        output stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
               id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        input  hazard_stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write
    );
    modport slave (
        input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
               id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, id_mem_write,
               mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
        output hazard_stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/ex_operand_stage_operand_forward_sel.sv
// operand_forward_sel: picks MEM result, then WB result, then register-file data for one source register.
module operand_forward_sel
    import ex_operand_stage_pkg::*;
(
    input  logic [RW-1:0] reg_i,
    input  logic [DW-1:0] reg_data_i,
    input  logic          mem_reg_write_i,
    input  logic [RW-1:0] mem_rd_i,
    input  logic [DW-1:0] mem_result_i,
    input  logic          wb_reg_write_i,
    input  logic [RW-1:0] wb_rd_i,
    input  logic [DW-1:0] wb_result_i,
    output logic [DW-1:0] fwd_o
);
    logic mem_hit, wb_hit;

    always_comb begin
        mem_hit = mem_reg_write_i && mem_rd_i != REG_ZERO && mem_rd_i == reg_i;
        wb_hit  = wb_reg_write_i && wb_rd_i != REG_ZERO && wb_rd_i == reg_i;
        fwd_o   = mem_hit ? mem_result_i : wb_hit ? wb_result_i : reg_data_i;
    end
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with load-use bubble insertion and MEM/WB operand forwarding.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    ex_operand_stage_if.slave        bus
);
    ex_regs_t      ex_q, ex_d;
    logic          hazard;
    logic [DW-1:0] fwd_rs, fwd_rt;

    always_comb begin
        ex_d = '{valid: bus.id_valid, rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                 rs_data: bus.id_rs_data, rt_data: bus.id_rt_data, imm: bus.id_imm,
                 alu_src: bus.id_alu_src, alu_ctrl: bus.id_alu_ctrl,
                 reg_write: bus.id_reg_write, mem_read: bus.id_mem_read,
                 mem_write: bus.id_mem_write};
        // rt only matters when it feeds the ALU or supplies store data
        hazard = bus.id_valid && ex_q.valid && ex_q.mem_read && ex_q.rd != REG_ZERO &&
                 (bus.id_rs == ex_q.rd ||
                  (bus.id_rt == ex_q.rd && (!bus.id_alu_src || bus.id_mem_write)));
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush || (!bus.stall && hazard))
            ex_q <= '0;
        else if (!bus.stall)
            ex_q <= ex_d;
    end

    operand_forward_sel u_fwd_rs (
        .reg_i(ex_q.rs), .reg_data_i(ex_q.rs_data),
        .mem_reg_write_i(bus.mem_reg_write), .mem_rd_i(bus.mem_rd), .mem_result_i(bus.mem_result),
        .wb_reg_write_i(bus.wb_reg_write), .wb_rd_i(bus.wb_rd), .wb_result_i(bus.wb_result),
        .fwd_o(fwd_rs)
    );

    operand_forward_sel u_fwd_rt (
        .reg_i(ex_q.rt), .reg_data_i(ex_q.rt_data),
        .mem_reg_write_i(bus.mem_reg_write), .mem_rd_i(bus.mem_rd), .mem_result_i(bus.mem_result),
        .wb_reg_write_i(bus.wb_reg_write), .wb_rd_i(bus.wb_rd), .wb_result_i(bus.wb_result),
        .fwd_o(fwd_rt)
    );

    always_comb begin
        bus.hazard_stall  = hazard;
        bus.ex_valid      = ex_q.valid;
        bus.alu_a         = ex_q.valid ? fwd_rs : '0;
        bus.alu_b         = !ex_q.valid ? '0 : ex_q.alu_src ? ex_q.imm : fwd_rt;
        bus.alu_ctrl      = ex_q.valid ? ex_q.alu_ctrl : ALU_ADD;
        bus.ex_store_data = ex_q.valid ? fwd_rt : '0;
        bus.ex_rd         = ex_q.valid ? ex_q.rd : REG_ZERO;
        bus.ex_reg_write  = ex_q.valid && ex_q.reg_write;
        bus.ex_mem_read   = ex_q.valid && ex_q.mem_read;
        bus.ex_mem_write  = ex_q.valid && ex_q.mem_write;
    end
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] a, b;
        logic [CW-1:0] c;
        logic [DW-1:0] sd;
        logic [RW-1:0] rd;
        logic          rw, mr, mw, hz;
    } obs_t;

    typedef struct {
        int    cyc;
        string name;
        obs_t  e;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    item_t sb[$];

    always #5 clk = ~clk;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [CW-1:0] c, input logic [DW-1:0] sd,
                                input logic [RW-1:0] rd, input logic rw, input logic mr,
                                input logic mw, input logic hz);
        return '{v, a, b, c, sd, rd, rw, mr, mw, hz};
    endfunction

    obs_t  act;
    item_t it;
    always @(negedge clk) begin
        act = '{bus.ex_valid, bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.ex_store_data, bus.ex_rd,
                bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.hazard_stall};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            n_chk++;
            if (it.cyc != cyc || act !== it.e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", it.name, act, it.e, cyc);
            end
        end
    end

    task automatic exp(input string name, input obs_t e);
        sb.push_back('{cyc, name, e});
    endtask

    task automatic clr();
        rst = 1'b0;
        bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
        bus.id_alu_src = 0; bus.id_alu_ctrl = '0;
        bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
        bus.mem_reg_write = 0; bus.mem_rd = '0; bus.mem_result = '0;
        bus.wb_reg_write = 0; bus.wb_rd = '0; bus.wb_result = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic id(input logic v, input logic [RW-1:0] rs, input logic [DW-1:0] rsd,
                      input logic [RW-1:0] rt, input logic [DW-1:0] rtd, input logic [RW-1:0] rd,
                      input logic src, input logic [DW-1:0] imm, input logic [CW-1:0] ctrl,
                      input logic rw, input logic mr, input logic mw);
        bus.id_valid = v; bus.id_rs = rs; bus.id_rs_data = rsd; bus.id_rt = rt;
        bus.id_rt_data = rtd; bus.id_rd = rd; bus.id_alu_src = src; bus.id_imm = imm;
        bus.id_alu_ctrl = ctrl; bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    task automatic rnd_id();
        id(1'b1, RW'($urandom), $urandom, RW'($urandom), $urandom, RW'($urandom), 1'($urandom),
           $urandom, CW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic mem(input logic w, input logic [RW-1:0] rd, input logic [DW-1:0] r);
        bus.mem_reg_write = w; bus.mem_rd = rd; bus.mem_result = r;
    endtask

    task automatic wb(input logic w, input logic [RW-1:0] rd, input logic [DW-1:0] r);
        bus.wb_reg_write = w; bus.wb_rd = rd; bus.wb_result = r;
    endtask

    obs_t zero, held, lw_hz;

    initial begin
        zero  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw_hz = mk(1, 32'h100, 32'h4, 4'h0, 32'h5, 5'd9, 1, 1, 0, 1);
        clr();
        rst = 1'b1;
        step(); rst = 1'b1; rnd_id();
        step(); exp("reset", zero);
        id(1, 5'd3, 32'h5, 5'd4, 32'h7, 5'd10, 0, 32'h0, 4'h0, 1, 0, 0);
        step(); exp("capture", mk(1, 32'h5, 32'h7, 4'h0, 32'h7, 5'd10, 1, 0, 0, 0));
        id(1, 5'd8, 32'h99, 5'd0, 32'h3, 5'd11, 0, 32'h0, 4'h1, 1, 0, 0);
        step(); bus.stall = 1; mem(1, 5'd8, 32'h11); wb(1, 5'd8, 32'h22);
        exp("fwd_mem_wins", mk(1, 32'h11, 32'h3, 4'h1, 32'h3, 5'd11, 1, 0, 0, 0));
        step(); bus.stall = 1; mem(1, 5'd5, 32'h44); wb(1, 5'd8, 32'h22);
        exp("fwd_wb", mk(1, 32'h22, 32'h3, 4'h1, 32'h3, 5'd11, 1, 0, 0, 0));
        step(); mem(1, 5'd0, 32'h77); wb(1, 5'd0, 32'h66);
        exp("fwd_reg0_none", mk(1, 32'h99, 32'h3, 4'h1, 32'h3, 5'd11, 1, 0, 0, 0));
        id(1, 5'd1, 32'h100, 5'd9, 32'h5, 5'd9, 1, 32'h4, 4'h0, 1, 1, 0);
        step(); exp("load_use_hazard", lw_hz);
        id(1, 5'd9, 32'haa, 5'd2, 32'h3, 5'd12, 0, 32'h0, 4'h0, 1, 0, 0);
        step(); id(1, 5'd9, 32'haa, 5'd2, 32'h3, 5'd12, 0, 32'h0, 4'h0, 1, 0, 0);
        mem(1, 5'd9, 32'h1234); exp("load_use_bubble", zero);
        step(); mem(1, 5'd9, 32'h1234); bus.stall = 1;
        held = mk(1, 32'h1234, 32'h3, 4'h0, 32'h3, 5'd12, 1, 0, 0, 0);
        exp("load_use_fwd", held);
        for (int i = 1; i <= 3; i++) begin
            step(); mem(1, 5'd9, 32'h1234); bus.stall = 1;
            id(1, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 0, 32'h0, 4'h5, 1, 1, 0);
            exp($sformatf("stall_hold_%0d", i), held);
        end
        bus.flush = 1;
        step(); exp("flush_over_stall", zero);
        id(1, 5'd1, 32'h100, 5'd9, 32'h5, 5'd9, 1, 32'h4, 4'h0, 1, 1, 0);
        step(); exp("store_rt_hazard", lw_hz); bus.stall = 1;
        id(1, 5'd2, 32'h200, 5'd9, 32'h0, 5'd0, 1, 32'hFFFFFFFC, 4'h0, 0, 0, 1);
        step(); exp("stall_with_hazard", lw_hz);
        id(1, 5'd2, 32'h200, 5'd9, 32'h0, 5'd0, 1, 32'hFFFFFFFC, 4'h0, 0, 0, 1);
        step(); exp("store_bubble", zero);
        id(1, 5'd2, 32'h200, 5'd9, 32'h0, 5'd0, 1, 32'hFFFFFFFC, 4'h0, 0, 0, 1);
        step(); mem(1, 5'd9, 32'h55);
        exp("imm_store_fwd", mk(1, 32'h200, 32'hFFFFFFFC, 4'h0, 32'h55, 5'd0, 0, 0, 1, 0));
        rst = 1'b1; rnd_id();
        step(); exp("mid_reset", zero);
        step();
        step();
        if (sb.size() != 0) begin
            n_fail += sb.size();
            $display("FAIL scoreboard_drain: got %0d unchecked entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
